// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//   Central stall/flush controller for the 5-stage pipeline. It merges
//   load-use hazard detection, the ID-stage taken-branch flush and a
//   data-memory miss FSM that freezes the whole pipeline until the refill
//   acknowledge arrives. It also keeps a saturating stall-cycle counter and a
//   sticky miss-timeout error flag.
//
// Parameters
//   MISS_TIMEOUT : MISS cycles without dmem_ack_i before err_o sets (>= 1)
//   CNT_W        : width of stall_cnt_o
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous active-low reset
//   start_i        in   CPU run enable; low holds everything
//   IFID_rs1_i     in   rs1 of instruction in ID
//   IFID_rs2_i     in   rs2 of instruction in ID
//   IDEX_MemRead_i in   instruction in EX is a load
//   IDEX_rd_i      in   rd of instruction in EX
//   branch_taken_i in   branch in ID resolved taken
//   dmem_req_i     in   MEM stage issues a load/store this cycle
//   dmem_hit_i     in   data cache hit for the current request
//   dmem_ack_i     in   memory refill complete (1-cycle pulse)
//   pc_write_o     out  PC write enable
//   ifid_stall_o   out  IF/ID stall
//   ifid_flush_o   out  IF/ID flush
//   idex_noop_o    out  bubble select into ID/EX
//   pipe_stall_o   out  global pipeline freeze
//   stall_cnt_o    out  saturating count of stalled cycles
//   err_o          out  sticky miss-timeout flag
// -----------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int MISS_TIMEOUT = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       IFID_rs1_i,
    input  logic [4:0]       IFID_rs2_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_rd_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_hit_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_noop_o,
    output logic             pipe_stall_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int TMR_W = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(MISS_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MISS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    logic miss_now_s;
    logic miss_wait_s;
    logic load_use_s;
    logic freeze_s;
    logic pc_write_s;
    logic ifid_stall_s;
    logic ifid_flush_s;
    logic idex_noop_s;
    logic pipe_stall_s;
    logic stall_evt_s;

    // Hazard terms, next-state logic and prioritised control outputs
    always_comb begin
        miss_now_s   = 1'b0;
        miss_wait_s  = 1'b0;
        load_use_s   = 1'b0;
        freeze_s     = 1'b0;
        state_nxt_s  = state_r;
        pc_write_s   = 1'b0;
        ifid_stall_s = 1'b0;
        ifid_flush_s = 1'b0;
        idex_noop_s  = 1'b0;
        pipe_stall_s = 1'b0;

        // A new miss is only recognised in RUN; requests seen in MISS are ignored.
        miss_now_s = start_i & dmem_req_i & ~dmem_hit_i & (state_r == ST_RUN);
        // A MISS cycle that counts toward the timeout.
        miss_wait_s = start_i & (state_r == ST_MISS) & ~dmem_ack_i;
        load_use_s = IDEX_MemRead_i & (IDEX_rd_i != 5'd0) &
                     ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i));
        // Mealy freeze: the missing request cycle itself is already frozen.
        freeze_s = start_i & ((state_r == ST_MISS) | miss_now_s);

        case (state_r)
            ST_RUN: begin
                if (miss_now_s) begin
                    state_nxt_s = ST_MISS;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MISS: begin
                // While start_i is low the FSM holds, so the ack is not taken.
                if (start_i & dmem_ack_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_MISS;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase

        if (!rst_i) begin
            pc_write_s = 1'b0;
        end else if (!start_i) begin
            ifid_stall_s = 1'b1;
        end else if (freeze_s) begin
            pipe_stall_s = 1'b1;
        end else if (load_use_s) begin
            // A taken branch in the same cycle re-resolves after the stall.
            ifid_stall_s = 1'b1;
            idex_noop_s  = 1'b1;
        end else if (branch_taken_i) begin
            pc_write_s   = 1'b1;
            ifid_flush_s = 1'b1;
        end else begin
            pc_write_s = 1'b1;
        end

        stall_evt_s = start_i & (pipe_stall_s | ifid_stall_s);
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Miss timer and sticky timeout error
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            timer_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (miss_now_s) begin
                timer_r <= '0;
            end else if (miss_wait_s && (timer_r < TMR_MAX)) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
            // Set on the cycle the timer reaches the limit.
            if (miss_wait_s && (timer_r == TMR_LAST)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= '0;
        end else if (stall_evt_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign pc_write_o   = pc_write_s;
    assign ifid_stall_o = ifid_stall_s;
    assign ifid_flush_o = ifid_flush_s;
    assign idex_noop_o  = idex_noop_s;
    assign pipe_stall_o = pipe_stall_s;
    assign stall_cnt_o  = cnt_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//   Scoreboard bench. Two instances share every input: dut_d with default
//   parameters and dut_s with MISS_TIMEOUT=4, CNT_W=4. Each directed step
//   drives inputs after a rising edge and queues the hand-computed control
//   vector plus expected counter/error values; the monitor pops and compares
//   on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_sequencer;

    // Control vector order: {pc_write, ifid_stall, ifid_flush, idex_noop, pipe_stall}
    localparam logic [4:0] C_RST  = 5'b00000;
    localparam logic [4:0] C_RUN  = 5'b10000;
    localparam logic [4:0] C_LU   = 5'b01010;
    localparam logic [4:0] C_BR   = 5'b10100;
    localparam logic [4:0] C_FRZ  = 5'b00001;
    localparam logic [4:0] C_HOLD = 5'b01000;

    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] cnt_d;
        logic [3:0]  cnt_s;
        logic        err_d;
        logic        err_s;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic start_i = 1'b0;
    logic [4:0] IFID_rs1_i = 5'd0;
    logic [4:0] IFID_rs2_i = 5'd0;
    logic IDEX_MemRead_i = 1'b0;
    logic [4:0] IDEX_rd_i = 5'd0;
    logic branch_taken_i = 1'b0;
    logic dmem_req_i = 1'b0;
    logic dmem_hit_i = 1'b1;
    logic dmem_ack_i = 1'b0;

    logic pc_d, ifs_d, iff_d, noop_d, pipe_d, err_d;
    logic pc_s, ifs_s, iff_s, noop_s, pipe_s, err_s;
    logic [31:0] cnt_d;
    logic [3:0]  cnt_s;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_cnt_d = 32'd0;
    logic [3:0]  m_cnt_s = 4'd0;
    logic exp_err_d = 1'b0;
    logic exp_err_s = 1'b0;

    always #5 clk_i = ~clk_i;

    hazard_sequencer dut_d (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rd_i(IDEX_rd_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i),
        .dmem_hit_i(dmem_hit_i), .dmem_ack_i(dmem_ack_i),
        .pc_write_o(pc_d), .ifid_stall_o(ifs_d), .ifid_flush_o(iff_d),
        .idex_noop_o(noop_d), .pipe_stall_o(pipe_d),
        .stall_cnt_o(cnt_d), .err_o(err_d)
    );

    hazard_sequencer #(.MISS_TIMEOUT(4), .CNT_W(4)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rd_i(IDEX_rd_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i),
        .dmem_hit_i(dmem_hit_i), .dmem_ack_i(dmem_ack_i),
        .pc_write_o(pc_s), .ifid_stall_o(ifs_s), .ifid_flush_o(iff_s),
        .idex_noop_o(noop_s), .pipe_stall_o(pipe_s),
        .stall_cnt_o(cnt_s), .err_o(err_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, compared on the falling edge
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctl_d", {27'd0, pc_d, ifs_d, iff_d, noop_d, pipe_d}, {27'd0, e.ctl});
            chk("ctl_s", {27'd0, pc_s, ifs_s, iff_s, noop_s, pipe_s}, {27'd0, e.ctl});
            chk("cnt_d", cnt_d, e.cnt_d);
            chk("cnt_s", {28'd0, cnt_s}, {28'd0, e.cnt_s});
            chk("err_d", {31'd0, err_d}, {31'd0, e.err_d});
            chk("err_s", {31'd0, err_s}, {31'd0, e.err_s});
            chk("stall_flush_excl", {31'd0, ifs_d & iff_d}, 32'd0);
        end
    end

    // Drive one cycle of inputs and queue the expected response for it
    task automatic step(input logic rst, input logic st,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic rq, input logic ht, input logic ak,
                        input logic [4:0] ctl);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i = rst; start_i = st;
        IFID_rs1_i = rs1; IFID_rs2_i = rs2;
        IDEX_MemRead_i = mr; IDEX_rd_i = rd; branch_taken_i = br;
        dmem_req_i = rq; dmem_hit_i = ht; dmem_ack_i = ak;
        if (!rst) begin
            m_cnt_d = 32'd0;
            m_cnt_s = 4'd0;
            exp_err_d = 1'b0;
            exp_err_s = 1'b0;
        end
        e.ctl = ctl; e.cnt_d = m_cnt_d; e.cnt_s = m_cnt_s;
        e.err_d = exp_err_d; e.err_s = exp_err_s;
        q.push_back(e);
        // Counter expectation for the next cycle: stalled cycles with start high.
        if (rst && st && (ctl[0] || ctl[3])) begin
            if (m_cnt_d != 32'hFFFF_FFFF) m_cnt_d = m_cnt_d + 32'd1;
            if (m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 4'd1;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_RUN);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_RST);
    endtask

    initial begin
        // Reset state
        do_reset();
        do_reset();
        idle();

        // Load-use on rs2, then rd=0 must not stall
        step(1'b1, 1'b1, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);
        step(1'b1, 1'b1, 5'd1, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, C_RUN);
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_RUN);
        // Load-use on rs1
        step(1'b1, 1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);

        // Branch flush for one cycle; branch with load-use only stalls
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, C_BR);
        idle();
        step(1'b1, 1'b1, 5'd3, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, C_LU);
        idle();

        // Miss: request at cycle 0, ack at cycle 6, count 7 at cycle 7
        do_reset();
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FRZ);
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) exp_err_s = 1'b1;  // small-timeout instance expired after 4 MISS cycles
            step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FRZ);
        end
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, C_FRZ);
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_RUN);
        // Ack while in RUN is ignored
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN);
        // Freeze outranks a concurrent load-use
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_FRZ);
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, C_FRZ);
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);

        // Timeout: err rises after 4 MISS cycles and survives a later ack
        do_reset();
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FRZ);
        for (int i = 1; i <= 7; i++) begin
            if (i == 5) exp_err_s = 1'b1;
            step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FRZ);
        end
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_FRZ);
        idle();
        idle();
        // Reset asserted mid-MISS clears freeze and err within the same cycle
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FRZ);
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FRZ);
        step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST);
        idle();

        // start_i low during load-use, then resume
        step(1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD);
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);
        // start_i low during MISS ignores the ack; MISS persists afterwards
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FRZ);
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_HOLD);
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_HOLD);
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ);
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_FRZ);
        idle();

        // Saturation: 20 stall cycles -> 4-bit counter holds at 15, 32-bit at 20
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 5'd0, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);
        end
        idle();
        idle();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk_i);
        chk("scoreboard_drain", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
